aibcr3aux_osc_hs_tx: RTL and testbench

- Transmit end of the aux four-phase CDC handshake. Runs in the source CP domain.
- Captures a data word and drives a glitch-free request level plus held data. The far-end 3-flop synchronizer samples these in the oscillator domain.
- Returns to idle only after the far-end ack has risen and then fallen, as seen through a local 3-flop synchronizer.
- Adds a timeout with a sticky error flag. The ack synchronizer is on the scan chain.

---
 rtl/aibcr3aux_hs_pkg.sv | 13 +
 rtl/aibcr3_sync_3ff.sv | 24 ++
 rtl/aibcr3aux_osc_hs_tx.sv | 118 +++++++++++
 tb/tb_aibcr3aux_osc_hs_tx.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aibcr3aux_hs_pkg.sv
// Shared definitions for the aux four-phase handshake transmit and receive ends.
package aibcr3aux_hs_pkg;

    typedef enum logic [1:0] {
        HS_IDLE   = 2'd0,
        HS_REQ_HI = 2'd1,
        HS_REQ_LO = 2'd2
    } hs_state_e;

    localparam int HS_DATA_W  = 8;
    localparam int HS_TMO_CYC = 255;

endpackage

// File: rtl/aibcr3_sync_3ff.sv
// Three-flop level synchronizer with a mux-scan input on the first stage.
module aibcr3_sync_3ff (
    input  logic SE,
    input  logic D,
    input  logic CP,
    input  logic SI,
    input  logic CDN,
    output logic Q
);

    logic [2:0] sync_r;

    // Shift chain: scan input replaces D on the first stage when SE is high.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], (SE ? SI : D)};
        end
    end

    assign Q = sync_r[2];

endmodule

// File: rtl/aibcr3aux_osc_hs_tx.sv
// Transmit end of the aux four-phase CDC handshake, clocked in the source CP domain.
module aibcr3aux_osc_hs_tx
    import aibcr3aux_hs_pkg::*;
#(
    parameter int DATA_W  = HS_DATA_W,
    parameter int TMO_CYC = HS_TMO_CYC,
    parameter int TMO_W   = 8
) (
    input  logic              CP,
    input  logic              CDN,
    input  logic              send_vld,
    input  logic [DATA_W-1:0] send_data,
    output logic              send_rdy,
    output logic              req,
    output logic [DATA_W-1:0] req_data,
    input  logic              ack_async,
    output logic              busy,
    output logic              done,
    output logic              tmo_err,
    input  logic              clr_err,
    input  logic              se_n,
    input  logic              si,
    output logic              so
);

    localparam bit               TMO_EN   = (TMO_CYC != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_EN ? TMO_W'(TMO_CYC - 1) : {TMO_W{1'b0}};

    hs_state_e         state_r;
    logic              req_r;
    logic [DATA_W-1:0] req_data_r;
    logic              done_r;
    logic              tmo_err_r;
    logic              ack_seen_r;
    logic [TMO_W-1:0]  cnt_r;
    logic              ack_s;
    logic              tmo_hit_s;

    aibcr3_sync_3ff u_ack_sync (
        .SE  (~se_n),
        .D   (ack_async),
        .Q   (ack_s),
        .CP  (CP),
        .SI  (si),
        .CDN (CDN)
    );

    assign send_rdy  = (state_r == HS_IDLE) & ~ack_s;
    assign tmo_hit_s = TMO_EN & (state_r == HS_REQ_HI) & ~ack_s & (cnt_r == TMO_LAST);

    // Handshake sequencer. A timed-out request still waits for a late ack to
    // rise and fall before idling, so a stray ack never bleeds into the next word.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state_r    <= HS_IDLE;
            req_r      <= 1'b0;
            req_data_r <= {DATA_W{1'b0}};
            done_r     <= 1'b0;
            ack_seen_r <= 1'b0;
            cnt_r      <= {TMO_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                HS_IDLE: begin
                    if (send_vld && send_rdy) begin
                        req_data_r <= send_data;
                        req_r      <= 1'b1;
                        cnt_r      <= {TMO_W{1'b0}};
                        ack_seen_r <= 1'b0;
                        state_r    <= HS_REQ_HI;
                    end
                end
                HS_REQ_HI: begin
                    cnt_r <= cnt_r + TMO_W'(1);
                    if (ack_s) begin
                        req_r      <= 1'b0;
                        ack_seen_r <= 1'b1;
                        state_r    <= HS_REQ_LO;
                    end else if (tmo_hit_s) begin
                        req_r   <= 1'b0;
                        state_r <= HS_REQ_LO;
                    end
                end
                HS_REQ_LO: begin
                    if (ack_s) begin
                        ack_seen_r <= 1'b1;
                    end else if (ack_seen_r) begin
                        done_r  <= 1'b1;
                        state_r <= HS_IDLE;
                    end
                end
                default: begin
                    req_r   <= 1'b0;
                    state_r <= HS_IDLE;
                end
            endcase
        end
    end

    // Sticky timeout flag; a timeout in the same cycle as clr_err keeps it set.
    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            tmo_err_r <= 1'b0;
        end else if (tmo_hit_s) begin
            tmo_err_r <= 1'b1;
        end else if (clr_err) begin
            tmo_err_r <= 1'b0;
        end
    end

    assign req      = req_r;
    assign req_data = req_data_r;
    assign done     = done_r;
    assign tmo_err  = tmo_err_r;
    assign busy     = (state_r != HS_IDLE);
    assign so       = ack_s;

endmodule

// File: tb/tb_aibcr3aux_osc_hs_tx.sv
// Directed bench for the aux handshake transmitter with TMO_CYC=16.
module tb_aibcr3aux_osc_hs_tx;

    logic       CP;
    logic       CDN;
    logic       send_vld;
    logic [7:0] send_data;
    logic       send_rdy;
    logic       req;
    logic [7:0] req_data;
    logic       ack_async;
    logic       busy;
    logic       done;
    logic       tmo_err;
    logic       clr_err;
    logic       se_n;
    logic       si;
    logic       so;

    int errors = 0;
    int checks = 0;

    aibcr3aux_osc_hs_tx #(.DATA_W(8), .TMO_CYC(16), .TMO_W(8)) dut (
        .CP        (CP),
        .CDN       (CDN),
        .send_vld  (send_vld),
        .send_data (send_data),
        .send_rdy  (send_rdy),
        .req       (req),
        .req_data  (req_data),
        .ack_async (ack_async),
        .busy      (busy),
        .done      (done),
        .tmo_err   (tmo_err),
        .clr_err   (clr_err),
        .se_n      (se_n),
        .si        (si),
        .so        (so)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic cyc(input int n);
        repeat (n) @(negedge CP);
    endtask

    // Raise then drop ack and wait (bounded) for the done pulse.
    task automatic finish_hs(input string name);
        bit got;
        got = 1'b0;
        ack_async = 1'b1;
        cyc(5);
        ack_async = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            cyc(1);
            if (done === 1'b1) got = 1'b1;
        end
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: no done pulse within budget", name);
        end
    endtask

    task automatic test_reset();
        CDN = 1'b0; send_vld = 1'b0; send_data = 8'h00; ack_async = 1'b0;
        clr_err = 1'b0; se_n = 1'b1; si = 1'b0;
        cyc(2);
        checks++; if (req !== 1'b0)      begin errors++; $display("FAIL rst_req: got %b want 0", req); end
        checks++; if (req_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", req_data); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (tmo_err !== 1'b0)  begin errors++; $display("FAIL rst_tmo: got %b want 0", tmo_err); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (send_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy: got %b want 1", send_rdy); end
        CDN = 1'b1;
        cyc(1);
    endtask

    task automatic test_basic();
        send_vld = 1'b1; send_data = 8'hA5;
        cyc(1);
        send_vld = 1'b0; send_data = 8'h00;
        checks++; if (req !== 1'b1)       begin errors++; $display("FAIL basic_req: got %b want 1", req); end
        checks++; if (req_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", req_data); end
        checks++; if (send_rdy !== 1'b0)  begin errors++; $display("FAIL basic_rdy: got %b want 0", send_rdy); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        ack_async = 1'b1;
        cyc(3);
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL basic_req_hold: got %b want 1", req); end
        cyc(1);
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL basic_req_fall: got %b want 0", req); end
        ack_async = 1'b0;
        cyc(3);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early: got %b want 0", done); end
        cyc(1);
        checks++; if (done !== 1'b1)     begin errors++; $display("FAIL basic_done: got %b want 1", done); end
        checks++; if (send_rdy !== 1'b1) begin errors++; $display("FAIL basic_rdy_done: got %b want 1", send_rdy); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL basic_busy_done: got %b want 0", busy); end
        cyc(1);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", done); end
        checks++; if (req_data !== 8'hA5) begin errors++; $display("FAIL basic_data_hold: got %h want a5", req_data); end
    endtask

    task automatic test_back_to_back();
        int n_acc, viol;
        bit seen_done, after_done, prev_req, prev_busy, fin;
        logic [7:0] prev_data, w0, w1;
        n_acc = 0; viol = 0; seen_done = 1'b0; after_done = 1'b0; fin = 1'b0;
        prev_req = 1'b0; prev_busy = 1'b0; prev_data = 8'h00; w0 = 8'h00; w1 = 8'h00;
        send_vld = 1'b1; send_data = 8'h01;
        for (int i = 0; i < 120 && !fin; i++) begin
            cyc(1);
            if (busy && prev_busy && (req_data !== prev_data)) viol++;
            if (done === 1'b1) begin
                if (n_acc == 2) fin = 1'b1;
                seen_done = 1'b1;
            end
            if (req && !prev_req) begin
                if (n_acc == 0) begin
                    w0 = req_data; send_data = 8'h02; seen_done = 1'b0;
                end else begin
                    w1 = req_data; after_done = seen_done; send_vld = 1'b0;
                end
                n_acc++;
            end
            prev_req = req; prev_busy = busy; prev_data = req_data;
            ack_async = req;
        end
        ack_async = 1'b0; send_vld = 1'b0;
        checks++; if (n_acc != 2)      begin errors++; $display("FAIL b2b_count: got %0d want 2", n_acc); end
        checks++; if (fin !== 1'b1)    begin errors++; $display("FAIL b2b_finish: got %b want 1", fin); end
        checks++; if (w0 !== 8'h01)    begin errors++; $display("FAIL b2b_word0: got %h want 01", w0); end
        checks++; if (w1 !== 8'h02)    begin errors++; $display("FAIL b2b_word1: got %h want 02", w1); end
        checks++; if (after_done !== 1'b1) begin errors++; $display("FAIL b2b_order: got %b want 1", after_done); end
        checks++; if (viol != 0)       begin errors++; $display("FAIL b2b_stable: got %0d changes want 0", viol); end
        cyc(2);
    endtask

    task automatic test_timeout();
        int n_done;
        send_vld = 1'b1; send_data = 8'h5A;
        cyc(1);
        send_vld = 1'b0;
        cyc(15);
        checks++; if (req !== 1'b1)     begin errors++; $display("FAIL tmo_req_hold: got %b want 1", req); end
        checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", tmo_err); end
        cyc(1);
        checks++; if (req !== 1'b0)     begin errors++; $display("FAIL tmo_req_fall: got %b want 0", req); end
        checks++; if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_set: got %b want 1", tmo_err); end
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (done === 1'b1) n_done++;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_stuck_busy: got %b want 1", busy); end
        checks++; if (n_done != 0)   begin errors++; $display("FAIL tmo_no_done: got %0d want 0", n_done); end
        checks++; if (send_rdy !== 1'b0) begin errors++; $display("FAIL tmo_rdy: got %b want 0", send_rdy); end
        finish_hs("tmo_recover1");
        checks++; if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", tmo_err); end
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", tmo_err); end
        send_vld = 1'b1; send_data = 8'h66;
        cyc(1);
        send_vld = 1'b0;
        cyc(15);
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        checks++; if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_set_wins: got %b want 1", tmo_err); end
        checks++; if (req !== 1'b0)     begin errors++; $display("FAIL tmo2_req_fall: got %b want 0", req); end
        finish_hs("tmo_recover2");
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        cyc(1);
    endtask

    task automatic test_race();
        send_vld = 1'b1; send_data = 8'hC3;
        cyc(1);
        send_vld = 1'b0;
        cyc(12);
        ack_async = 1'b1;
        cyc(3);
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL race_req_hold: got %b want 1", req); end
        cyc(1);
        checks++; if (req !== 1'b0)     begin errors++; $display("FAIL race_req_fall: got %b want 0", req); end
        checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL race_tmo: got %b want 0", tmo_err); end
        ack_async = 1'b0;
        cyc(4);
        checks++; if (done !== 1'b1)    begin errors++; $display("FAIL race_done: got %b want 1", done); end
        checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL race_tmo_end: got %b want 0", tmo_err); end
        cyc(1);
    endtask

    task automatic test_scan();
        logic [3:0] pat;
        pat = 4'b1101;
        se_n = 1'b0;
        for (int i = 0; i < 7; i++) begin
            si = (i < 4) ? pat[i] : 1'b0;
            cyc(1);
            if (i >= 2 && i <= 5) begin
                checks++;
                if (so !== pat[i-2]) begin errors++; $display("FAIL scan_so%0d: got %b want %b", i - 2, so, pat[i-2]); end
                checks++;
                if (send_rdy !== ~pat[i-2]) begin errors++; $display("FAIL scan_rdy%0d: got %b want %b", i - 2, send_rdy, ~pat[i-2]); end
            end
        end
        se_n = 1'b1; si = 1'b0;
        cyc(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL scan_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        send_vld = 1'b1; send_data = 8'h3C;
        cyc(1);
        send_vld = 1'b0;
        cyc(2);
        checks++; if (req_data !== 8'h3C) begin errors++; $display("FAIL rmid_data: got %h want 3c", req_data); end
        #2 CDN = 1'b0;
        #1;
        checks++; if (req !== 1'b0)       begin errors++; $display("FAIL rmid_req: got %b want 0", req); end
        checks++; if (req_data !== 8'h00) begin errors++; $display("FAIL rmid_rdata: got %h want 00", req_data); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL rmid_done: got %b want 0", done); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        ack_async = 1'b1;
        cyc(1);
        CDN = 1'b1;
        #1;
        checks++; if (send_rdy !== 1'b1) begin errors++; $display("FAIL rmid_rdy_rel: got %b want 1", send_rdy); end
        cyc(3);
        send_vld = 1'b1; send_data = 8'h77;
        cyc(3);
        checks++; if (send_rdy !== 1'b0) begin errors++; $display("FAIL stale_rdy: got %b want 0", send_rdy); end
        checks++; if (req !== 1'b0)      begin errors++; $display("FAIL stale_req: got %b want 0", req); end
        ack_async = 1'b0;
        cyc(3);
        checks++; if (send_rdy !== 1'b1) begin errors++; $display("FAIL stale_rdy_clr: got %b want 1", send_rdy); end
        checks++; if (req !== 1'b0)      begin errors++; $display("FAIL stale_req_wait: got %b want 0", req); end
        cyc(1);
        send_vld = 1'b0;
        checks++; if (req !== 1'b1)       begin errors++; $display("FAIL stale_accept: got %b want 1", req); end
        checks++; if (req_data !== 8'h77) begin errors++; $display("FAIL stale_data: got %h want 77", req_data); end
        finish_hs("rmid_final");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_race();
        test_scan();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
